time_set_ctrl: RTL and testbench

- Time-keeping and time-setting controller for the digital clock.
- Consumes the debounced button outputs (mode and increment) from the pushbutton stages and a 1 Hz enable tick.
- Maintains hours/minutes/seconds registers and a run/set mode FSM.
- Drives the display path with time fields and a blink flag for the field being edited.

---
 rtl/time_set_ctrl_if.sv | 31 +++
 rtl/time_set_ctrl.sv | 152 +++++++++++++++
 tb/tb_time_set_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Button/tick inputs and time/display outputs of the time-setting controller.
//   tick_1hz        : one-cycle enable pulse, once per second
//   btn_mode        : debounced mode button (level, held for many cycles)
//   btn_inc         : debounced increment button (level)
//   hours           : 0..MAX_HOUR
//   minutes         : 0..MAX_MIN
//   seconds         : 0..MAX_MIN
//   mode            : 0 = RUN, 1 = SET_HR, 2 = SET_MIN
//   blink           : blank flag for the field under edit
// master drives the inputs and reads the time (display side / bench),
// slave is the controller itself.
interface time_set_ctrl_if;
    logic       tick_1hz;
    logic       btn_mode;
    logic       btn_inc;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output tick_1hz, btn_mode, btn_inc,
        input  hours, minutes, seconds, mode, blink
    );

    modport slave (
        input  tick_1hz, btn_mode, btn_inc,
        output hours, minutes, seconds, mode, blink
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time-keeping and time-setting controller for the digital clock.
// Counts hh:mm:ss on the 1 Hz tick in RUN; the mode button steps through
// RUN -> SET_HR -> SET_MIN -> RUN, and in the set states the increment button
// bumps the field under edit while the blink flag toggles once per tick.
//   clk_in : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : time_set_ctrl_if.slave (buttons, tick, time fields, mode, blink)
module time_set_ctrl #(
    parameter int unsigned MAX_HOUR = 23,
    parameter int unsigned MAX_MIN  = 59
) (
    input logic            clk_in,
    input logic            rst_n,
    time_set_ctrl_if.slave bus
);

    localparam logic [4:0] HourMax = 5'(MAX_HOUR);
    localparam logic [5:0] MinMax  = 6'(MAX_MIN);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] hours_q, hours_d;
    logic [5:0] minutes_q, minutes_d;
    logic [5:0] seconds_q, seconds_d;
    logic       blink_q, blink_d;

    // Two-stage edge detect per button.
    logic mode_b_q, mode_b_d, mode_b_qq, mode_b_qd;
    logic inc_b_q, inc_b_d, inc_b_qq, inc_b_qd;
    // Arm flags: set once the raw button has been seen low after reset, so a
    // button already held at reset release cannot fake a rising edge.
    logic mode_arm_q, mode_arm_d;
    logic inc_arm_q, inc_arm_d;

    logic mode_ev;
    logic inc_ev;

    always_comb begin
        mode_b_d   = bus.btn_mode;
        mode_b_qd  = mode_b_q;
        inc_b_d    = bus.btn_inc;
        inc_b_qd   = inc_b_q;
        mode_arm_d = mode_arm_q | ~bus.btn_mode;
        inc_arm_d  = inc_arm_q | ~bus.btn_inc;

        mode_ev = mode_b_q & ~mode_b_qq & mode_arm_q;
        inc_ev  = inc_b_q & ~inc_b_qq & inc_arm_q;
    end

    always_comb begin
        state_d   = state_q;
        hours_d   = hours_q;
        minutes_d = minutes_q;
        seconds_d = seconds_q;
        blink_d   = blink_q;

        unique case (state_q)
            StRun: begin
                // Tick and mode event on the same edge: both take effect.
                if (bus.tick_1hz) begin
                    if (seconds_q == MinMax) begin
                        seconds_d = '0;
                        if (minutes_q == MinMax) begin
                            minutes_d = '0;
                            hours_d   = (hours_q == HourMax) ? '0 : hours_q + 5'd1;
                        end else begin
                            minutes_d = minutes_q + 6'd1;
                        end
                    end else begin
                        seconds_d = seconds_q + 6'd1;
                    end
                end
                blink_d = 1'b0;
                if (mode_ev) begin
                    state_d = StSetHr;
                end
            end
            StSetHr: begin
                // Mode wins over a coincident increment.
                if (mode_ev) begin
                    state_d = StSetMin;
                    blink_d = 1'b0;
                end else begin
                    if (inc_ev) begin
                        hours_d = (hours_q == HourMax) ? '0 : hours_q + 5'd1;
                    end
                    if (bus.tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            StSetMin: begin
                if (mode_ev) begin
                    state_d   = StRun;
                    seconds_d = '0;
                    blink_d   = 1'b0;
                end else begin
                    if (inc_ev) begin
                        minutes_d = (minutes_q == MinMax) ? '0 : minutes_q + 6'd1;
                    end
                    if (bus.tick_1hz) begin
                        blink_d = ~blink_q;
                    end
                end
            end
            default: begin
                state_d = StRun;
                blink_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            hours_q    <= '0;
            minutes_q  <= '0;
            seconds_q  <= '0;
            blink_q    <= 1'b0;
            mode_b_q   <= 1'b0;
            mode_b_qq  <= 1'b0;
            inc_b_q    <= 1'b0;
            inc_b_qq   <= 1'b0;
            mode_arm_q <= 1'b0;
            inc_arm_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            minutes_q  <= minutes_d;
            seconds_q  <= seconds_d;
            blink_q    <= blink_d;
            mode_b_q   <= mode_b_d;
            mode_b_qq  <= mode_b_qd;
            inc_b_q    <= inc_b_d;
            inc_b_qq   <= inc_b_qd;
            mode_arm_q <= mode_arm_d;
            inc_arm_q  <= inc_arm_d;
        end
    end

    assign bus.hours   = hours_q;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;
    assign bus.mode    = state_q;
    assign bus.blink   = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge. Observed/expected values are packed
// as {hours[4:0], minutes[5:0], seconds[5:0], mode[1:0], blink}.
module tb_time_set_ctrl;

    logic clk_in;
    logic rst_n;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .MAX_HOUR(23),
        .MAX_MIN (59)
    ) dut (
        .clk_in(clk_in),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks;
    int errors;

    logic [19:0] obs;
    logic [19:0] exp_v;

    assign obs = {bus.hours, bus.minutes, bus.seconds, bus.mode, bus.blink};

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    function automatic logic [19:0] pack(int h, int m, int s, int md, int bl);
        return {5'(h), 6'(m), 6'(s), 2'(md), 1'(bl)};
    endfunction

    // Stimulus helpers: entered and left on a falling edge.
    task automatic press_mode();
        bus.btn_mode = 1'b1;
        repeat (3) @(negedge clk_in);
        bus.btn_mode = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic press_inc(int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_inc = 1'b1;
            repeat (3) @(negedge clk_in);
            bus.btn_inc = 1'b0;
            repeat (2) @(negedge clk_in);
        end
    endtask

    task automatic ticks(int n);
        bus.tick_1hz = 1'b1;
        repeat (n) @(negedge clk_in);
        bus.tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        rst_n        = 1'b1;
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        exp_v = pack(0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_assert: got %h expected %h", obs, exp_v);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        @(negedge clk_in);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_run_count();
        ticks(60);
        exp_v = pack(0, 1, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL run_60_ticks: got %h expected %h", obs, exp_v);
        end
        ticks(3540);
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL run_3600_ticks: got %h expected %h", obs, exp_v);
        end
        ticks(82800);
        exp_v = pack(0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL run_86400_ticks: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_carry_chain();
        press_mode();
        press_inc(23);
        exp_v = pack(23, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL set_hr_23: got %h expected %h", obs, exp_v);
        end
        press_mode();
        press_inc(59);
        exp_v = pack(23, 59, 0, 2, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL set_min_59: got %h expected %h", obs, exp_v);
        end
        press_mode();
        ticks(58);
        exp_v = pack(23, 59, 58, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL preload_235958: got %h expected %h", obs, exp_v);
        end
        ticks(2);
        exp_v = pack(0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL day_wrap: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_inc_hold();
        press_mode();
        press_inc(5);
        bus.btn_inc = 1'b1;
        repeat (200) @(negedge clk_in);
        exp_v = pack(6, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL inc_held_once: got %h expected %h", obs, exp_v);
        end
        bus.btn_inc = 1'b0;
        repeat (2) @(negedge clk_in);
        press_inc(19);
        exp_v = pack(1, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hour_inc_wrap: got %h expected %h", obs, exp_v);
        end
        press_mode();
        press_mode();
        press_inc(3);
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL inc_ignored_in_run: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_blink();
        ticks(5);
        exp_v = pack(1, 0, 5, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL run_5_ticks: got %h expected %h", obs, exp_v);
        end
        // Button first sampled at edge N; nothing may change until edge N+1.
        bus.btn_mode = 1'b1;
        @(negedge clk_in);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mode_not_at_edge_n: got %h expected %h", obs, exp_v);
        end
        // Tick lands on the same edge as the mode event.
        bus.tick_1hz = 1'b1;
        @(negedge clk_in);
        bus.tick_1hz = 1'b0;
        bus.btn_mode = 1'b0;
        exp_v = pack(1, 0, 6, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL tick_with_mode: got %h expected %h", obs, exp_v);
        end
        repeat (2) @(negedge clk_in);
        ticks(1);
        exp_v = pack(1, 0, 6, 1, 1);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL blink_on: got %h expected %h", obs, exp_v);
        end
        ticks(1);
        exp_v = pack(1, 0, 6, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL blink_off: got %h expected %h", obs, exp_v);
        end
        ticks(1);
        press_mode();
        exp_v = pack(1, 0, 6, 2, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL blink_clr_on_mode: got %h expected %h", obs, exp_v);
        end
        press_mode();
        exp_v = pack(1, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL exit_clears_sec: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_mode_inc_same_edge();
        press_mode();
        press_mode();
        press_inc(10);
        exp_v = pack(1, 10, 0, 2, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL set_min_10: got %h expected %h", obs, exp_v);
        end
        bus.btn_mode = 1'b1;
        bus.btn_inc  = 1'b1;
        repeat (3) @(negedge clk_in);
        exp_v = pack(1, 10, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL mode_beats_inc: got %h expected %h", obs, exp_v);
        end
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_async_reset();
        press_mode();
        press_mode();
        press_inc(32);
        exp_v = pack(1, 42, 0, 2, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL set_min_42: got %h expected %h", obs, exp_v);
        end
        // Assert reset between clock edges with the mode button held down.
        #2;
        rst_n        = 1'b0;
        bus.btn_mode = 1'b1;
        #1;
        exp_v = pack(0, 0, 0, 0, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs, exp_v);
        end
        repeat (3) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL held_btn_no_action: got %h expected %h", obs, exp_v);
        end
        bus.btn_mode = 1'b0;
        repeat (2) @(negedge clk_in);
        bus.btn_mode = 1'b1;
        @(negedge clk_in);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fresh_press_edge_n: got %h expected %h", obs, exp_v);
        end
        @(negedge clk_in);
        exp_v = pack(0, 0, 0, 1, 0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL fresh_press_acts: got %h expected %h", obs, exp_v);
        end
        bus.btn_mode = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_run_count();
        test_carry_chain();
        test_inc_hold();
        test_blink();
        test_mode_inc_same_edge();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
